ramb4_port_arbiter: RTL and testbench



---
 rtl/ramb4_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_ramb4_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb4_port_arbiter.sv
// ramb4_port_arbiter
//
// Two-requester round-robin arbiter and clear sequencer for one 512x8 port
// of a RAMB4 dual-port block RAM, all in the CLKA domain.
//
// Ports:
//   CLKA, RSTB            clock (rising edge) and synchronous active-high reset
//   req/we/addr/wdata 0,1 requester interfaces; req is held until granted
//   gnt0, gnt1            combinational grant, request consumed this cycle
//   rvalid0, rvalid1      read data valid, one cycle after a read grant
//   rdata                 shared read data (RAM registered output)
//   clr_start             pulse that starts a full-array clear
//   clr_busy, clr_done    clear in progress / pulse after the last clear write
//   ram_en, ram_we, ram_addr, ram_di, ram_rst, ram_do  RAM primitive port
module ramb4_port_arbiter #(
    parameter int                ADDR_W  = 9,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              CLKA,
    input  logic              RSTB,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    output logic              ram_rst,
    input  logic [DATA_W-1:0] ram_do
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_q, last_d;   // requester granted most recently
    logic              g0, g1;
    logic              done_d;
    logic              vld0_p1, vld1_p1, done_p1;

    // Stage 0: arbitration / clear sequencing, drives the RAM port directly
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        g0       = 1'b0;
        g1       = 1'b0;
        done_d   = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        // Nothing is granted while reset is held, so no access is issued
        // whose read result the reset would then discard.
        if (!RSTB) begin
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                    end else begin
                        // On conflict the requester not granted last wins.
                        g0 = req0 & (~req1 | last_q);
                        g1 = req1 & (~req0 | ~last_q);
                        if (g0) begin
                            ram_en   = 1'b1;
                            ram_we   = we0;
                            ram_addr = addr0;
                            ram_di   = wdata0;
                            last_d   = 1'b0;
                        end else if (g1) begin
                            ram_en   = 1'b1;
                            ram_we   = we1;
                            ram_addr = addr1;
                            ram_di   = wdata1;
                            last_d   = 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = cnt_q;
                    ram_di   = CLR_VAL;
                    if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage 1: registered control and read-valid, aligned with ram_do
    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            vld0_p1 <= g0 & ~we0;
            vld1_p1 <= g1 & ~we1;
            done_p1 <= done_d;
        end
    end

    assign gnt0     = g0;
    assign gnt1     = g1;
    assign rvalid0  = vld0_p1;
    assign rvalid1  = vld1_p1;
    assign rdata    = ram_do;
    assign clr_busy = (state_q == CLEAR);
    assign clr_done = done_p1;
    assign ram_rst  = 1'b0;

endmodule

// File: tb/tb_ramb4_port_arbiter.sv
// Testbench for ramb4_port_arbiter: behavioural RAMB4 port model, randomized
// requester traffic against a reference model, a vector table for the basic
// read/write/contention cases, and hand-written clear sequences.
module tb_ramb4_port_arbiter;

    logic       CLKA = 1'b0;
    logic       RSTB = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [8:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       clr_start = 1'b0;
    logic       clr_busy, clr_done;
    logic       ram_en, ram_we, ram_rst;
    logic [8:0] ram_addr;
    logic [7:0] ram_di;
    logic [7:0] ram_do;

    always #5 CLKA = ~CLKA;

    ramb4_port_arbiter #(.ADDR_W(9), .DATA_W(8), .CLR_VAL(8'h00)) dut (
        .CLKA(CLKA), .RSTB(RSTB),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .clr_start(clr_start), .clr_busy(clr_busy),
        .clr_done(clr_done), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_rst(ram_rst),
        .ram_do(ram_do)
    );

    // Initial RAM contents
    function automatic logic [7:0] init_val(int i);
        case (i)
            5:       return 8'hA5;
            16:      return 8'h11;
            32:      return 8'h22;
            default: return i[7:0] ^ 8'h96;
        endcase
    endfunction

    // Behavioural RAM port: registered output, write-first
    logic [7:0] mem [0:511];
    bit         ram_loaded = 1'b0;
    always @(posedge CLKA) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_di;
                ram_do        <= ram_di;
            end else begin
                ram_do <= mem[ram_addr];
            end
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        bit rst; bit chk;
        bit r0; bit w0; logic [8:0] a0; logic [7:0] d0;
        bit r1; bit w1; logic [8:0] a1; logic [7:0] d1;
        bit eg0; bit eg1; bit erv0; bit erv1; logic [7:0] erd;
    } vec_t;

    function automatic vec_t mk(bit rst, bit ck, bit r0, bit w0, logic [8:0] a0, logic [7:0] d0,
                                bit r1, bit w1, logic [8:0] a1, logic [7:0] d1,
                                bit eg0, bit eg1, bit erv0, bit erv1, logic [7:0] erd);
        vec_t v;
        v.rst = rst; v.chk = ck;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
        return v;
    endfunction

    // Clear sequence starting with clr_start at cycle 0; optional second
    // clr_start at cycle second_at and RSTB at cycle rst_at (-1 = none).
    // Starts and ends at posedge+1.
    task automatic run_clear(input int second_at, input int rst_at);
        int  last_c    = (rst_at >= 0) ? rst_at + 5 : 516;
        int  clear_end = (rst_at >= 0) ? rst_at : 512;
        bit  prev_g    = 1'b0;
        bit  busy_e, done_e, g_e;
        for (int c = 0; c <= last_c; c++) begin
            clr_start = (c == 0) || (c == second_at);
            RSTB      = (c == rst_at);
            req0 = 1'b1; we0 = 1'b0; addr0 = 9'h000;
            @(negedge CLKA);
            busy_e = (c >= 1) && (c <= clear_end);
            done_e = (rst_at < 0) && (c == 513);
            g_e    = (c != 0) && !busy_e;
            chk("clr_gnt0", gnt0, g_e);
            chk("clr_busy", clr_busy, busy_e);
            chk("clr_done", clr_done, done_e);
            if (busy_e && c != rst_at) begin
                chk("clr_en", ram_en, 1'b1);
                chk("clr_we", ram_we, 1'b1);
                chk("clr_addr", ram_addr, c - 1);
                chk("clr_di", ram_di, 8'h00);
            end
            if (c >= 1) begin
                chk("clr_rvalid0", rvalid0, prev_g);
                if (prev_g) chk("clr_rdata", rdata, 8'h00);
            end
            prev_g = g_e;
            @(posedge CLKA); #1;
        end
        clr_start = 1'b0;
        RSTB      = 1'b0;
        req0      = 1'b0;
    endtask

    vec_t       vt [12];
    logic [7:0] shadow [0:511];
    bit         p0 = 0, p1 = 0, pw0 = 0, pw1 = 0;
    logic [8:0] pa0 = '0, pa1 = '0;
    logic [7:0] pd0 = '0, pd1 = '0;
    int         last_win;
    bit         xrv0, xrv1;
    logic [7:0] xrd;

    initial begin
        int win;
        for (int i = 0; i < 512; i++) shadow[i] = init_val(i);

        // Reset state
        repeat (3) @(posedge CLKA);
        @(negedge CLKA);
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_rvalid0", rvalid0, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        chk("rst_en", ram_en, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_ramrst", ram_rst, 1'b0);
        @(posedge CLKA); #1;
        RSTB = 1'b0;

        // Randomized traffic against the reference model
        last_win = 1;
        xrv0 = 0; xrv1 = 0; xrd = '0;
        for (int n = 0; n < 300; n++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; pw0 = 1'($urandom_range(0, 1));
                pa0 = 9'h100 + 9'($urandom_range(0, 15)); pd0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1; pw1 = 1'($urandom_range(0, 1));
                pa1 = 9'h100 + 9'($urandom_range(0, 15)); pd1 = 8'($urandom);
            end
            req0 = p0; we0 = pw0; addr0 = pa0; wdata0 = pd0;
            req1 = p1; we1 = pw1; addr1 = pa1; wdata1 = pd1;
            @(negedge CLKA);
            if (p0 && p1) win = 1 - last_win;
            else if (p0)  win = 0;
            else if (p1)  win = 1;
            else          win = -1;
            chk("rnd_gnt0", gnt0, win == 0);
            chk("rnd_gnt1", gnt1, win == 1);
            chk("rnd_rvalid0", rvalid0, xrv0);
            chk("rnd_rvalid1", rvalid1, xrv1);
            if (xrv0 || xrv1) chk("rnd_rdata", rdata, xrd);
            chk("rnd_en", ram_en, win >= 0);
            xrv0 = 0; xrv1 = 0;
            if (win == 0) begin
                chk("rnd_addr", ram_addr, pa0);
                chk("rnd_we", ram_we, pw0);
                if (pw0) begin chk("rnd_di", ram_di, pd0); shadow[pa0] = pd0; end
                else begin xrv0 = 1; xrd = shadow[pa0]; end
                p0 = 0; last_win = 0;
            end else if (win == 1) begin
                chk("rnd_addr", ram_addr, pa1);
                chk("rnd_we", ram_we, pw1);
                if (pw1) begin chk("rnd_di", ram_di, pd1); shadow[pa1] = pd1; end
                else begin xrv1 = 1; xrd = shadow[pa1]; end
                p1 = 0; last_win = 1;
            end
            @(posedge CLKA); #1;
        end
        req0 = 0; req1 = 0;

        // Vector table: rst, chk, req0 fields, req1 fields, expected outputs
        vt[0]  = mk(1, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[1]  = mk(0, 1, 1, 0, 9'h005, 8'h00, 0, 0, 9'h000, 8'h00, 1, 0, 0, 0, 8'h00);
        vt[2]  = mk(0, 1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 1, 0, 8'hA5);
        vt[3]  = mk(1, 1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 0, 8'h00);
        vt[4]  = mk(0, 1, 1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00, 1, 0, 0, 0, 8'h00);
        vt[5]  = mk(0, 1, 1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00, 0, 1, 1, 0, 8'h11);
        vt[6]  = mk(0, 1, 1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00, 1, 0, 0, 1, 8'h22);
        vt[7]  = mk(0, 1, 1, 0, 9'h010, 8'h00, 1, 0, 9'h020, 8'h00, 0, 1, 1, 0, 8'h11);
        vt[8]  = mk(0, 1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 1, 8'h22);
        vt[9]  = mk(0, 1, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h3C, 0, 1, 0, 0, 8'h00);
        vt[10] = mk(0, 1, 0, 0, 9'h000, 8'h00, 1, 0, 9'h1FF, 8'h00, 0, 1, 0, 0, 8'h00);
        vt[11] = mk(0, 1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 1, 8'h3C);
        for (int i = 0; i < 12; i++) begin
            RSTB = vt[i].rst;
            req0 = vt[i].r0; we0 = vt[i].w0; addr0 = vt[i].a0; wdata0 = vt[i].d0;
            req1 = vt[i].r1; we1 = vt[i].w1; addr1 = vt[i].a1; wdata1 = vt[i].d1;
            @(negedge CLKA);
            if (vt[i].chk) begin
                chk($sformatf("vec%0d_gnt0", i), gnt0, vt[i].eg0);
                chk($sformatf("vec%0d_gnt1", i), gnt1, vt[i].eg1);
                chk($sformatf("vec%0d_rvalid0", i), rvalid0, vt[i].erv0);
                chk($sformatf("vec%0d_rvalid1", i), rvalid1, vt[i].erv1);
                if (vt[i].erv0 || vt[i].erv1) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].erd);
                chk($sformatf("vec%0d_en", i), ram_en, vt[i].eg0 | vt[i].eg1);
                if (vt[i].eg0) begin
                    chk($sformatf("vec%0d_addr", i), ram_addr, vt[i].a0);
                    chk($sformatf("vec%0d_we", i), ram_we, vt[i].w0);
                end
                if (vt[i].eg1) begin
                    chk($sformatf("vec%0d_addr", i), ram_addr, vt[i].a1);
                    chk($sformatf("vec%0d_we", i), ram_we, vt[i].w1);
                    if (vt[i].w1) chk($sformatf("vec%0d_di", i), ram_di, vt[i].d1);
                end
            end
            @(posedge CLKA); #1;
        end
        RSTB = 0; req0 = 0; req1 = 0;

        // Full clear with req0 held, then read back the top address
        run_clear(-1, -1);
        req0 = 1; we0 = 0; addr0 = 9'h1FF;
        @(negedge CLKA);
        chk("post_clr_gnt0", gnt0, 1'b1);
        @(posedge CLKA); #1;
        req0 = 0;
        @(negedge CLKA);
        chk("post_clr_rvalid0", rvalid0, 1'b1);
        chk("post_clr_rdata", rdata, 8'h00);
        @(posedge CLKA); #1;

        // Second clr_start mid-clear is ignored
        run_clear(100, -1);

        // Reset mid-clear, then a new clear starts at address 0
        run_clear(-1, 200);
        clr_start = 1;
        @(negedge CLKA);
        chk("restart_busy_before", clr_busy, 1'b0);
        @(posedge CLKA); #1;
        clr_start = 0;
        @(negedge CLKA);
        chk("restart_busy", clr_busy, 1'b1);
        chk("restart_addr", ram_addr, 9'h000);
        chk("restart_di", ram_di, 8'h00);
        @(posedge CLKA); #1;
        RSTB = 1;
        @(posedge CLKA); #1;
        RSTB = 0;
        @(negedge CLKA);
        chk("final_busy", clr_busy, 1'b0);
        chk("final_done", clr_done, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
